// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
//   state_e : controller states
//   DW_DEF  : default divisor/quotient/remainder width
//   NBYTES  : operand bytes per operation (dividend 2*DW + divisor DW, in bytes)
//   CNT_W   : iteration counter width
package div_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int DW_DEF = 16;

  function automatic int nbytes(input int dw);
    return 3 * dw / 8;
  endfunction

  function automatic int cnt_w(input int dw);
    return $clog2(dw);
  endfunction

  localparam int NBYTES = nbytes(DW_DEF);
  localparam int CNT_W  = cnt_w(DW_DEF);
endpackage

// File: rtl/seq_divider_if.sv
// Operand/result bus of the sequential divider.
//   clr                 : synchronous abort
//   in_valid/in_ready   : byte handshake, in_data carries the operand byte
//   busy, done/ack      : status and result handshake
//   q, r, dz, ovf       : quotient, remainder, divide-by-zero, overflow
// master = operand source / result consumer, slave = divider.
interface seq_divider_if #(parameter int DW = 16);
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          busy;
  logic          done;
  logic          ack;
  logic [DW-1:0] q;
  logic [DW-1:0] r;
  logic          dz;
  logic          ovf;

  modport master (
    output clr, in_valid, in_data, ack,
    input  in_ready, busy, done, q, r, dz, ovf
  );

  modport slave (
    input  clr, in_valid, in_data, ack,
    output in_ready, busy, done, q, r, dz, ovf
  );
endinterface

// File: rtl/div_dp.sv
// Datapath of the radix-2 restoring divider.
//   clk, rst   : clock, async active-high reset
//   clr_i      : synchronous clear of all state
//   shift_i    : accept in_data_i into the operand shift register
//   prep_i     : PREP cycle (zero/early-overflow checks, P/Q load)
//   calc_i     : one quotient-bit iteration
//   fix_i      : result load (with sign fix-up when signed)
//   ack_i      : result consumed, clears dz/ovf
//   early_o    : PREP resolves without iterating (dz or early overflow)
//   q_o, r_o, dz_o, ovf_o : result registers
// Optional feature: SIGNED_DIV_EN builds the sign registers and negators.
module div_dp
  import div_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          shift_i,
  input  logic [7:0]    in_data_i,
  input  logic          prep_i,
  input  logic          calc_i,
  input  logic          fix_i,
  input  logic          ack_i,
  output logic          early_o,
  output logic [DW-1:0] q_o,
  output logic [DW-1:0] r_o,
  output logic          dz_o,
  output logic          ovf_o
);
  logic [3*DW-1:0] sh_q;
  logic [2*DW-1:0] dvd, dvd_mag;
  logic [DW-1:0]   dvs, dvs_mag;
  logic [DW-1:0]   p_q, p_d, qr_q, qr_d, d_q;
  logic [DW:0]     t;
  logic [DW-1:0]   q_q, r_q, fix_q, fix_r;
  logic            dz_q, ovf_q, fix_ovf;
  logic            div_zero, early_ovf;

  // Bytes arrive MSB first, so after the last byte the dividend sits on top.
  assign dvd = sh_q[3*DW-1:DW];
  assign dvs = sh_q[DW-1:0];

`ifdef SIGNED_DIV_EN
  logic sd_q, sv_q, neg;

  assign dvd_mag = dvd[2*DW-1] ? -dvd : dvd;
  assign dvs_mag = dvs[DW-1]   ? -dvs : dvs;
  assign neg     = sd_q ^ sv_q;

  // Magnitude quotient may reach 2^(DW-1) only when the result is negative.
  always_comb begin
    fix_ovf = qr_q[DW-1] && (!neg || (qr_q[DW-2:0] != '0));
    fix_q   = neg  ? -qr_q : qr_q;
    fix_r   = sd_q ? -p_q  : p_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sd_q <= 1'b0;
      sv_q <= 1'b0;
    end else if (clr_i) begin
      sd_q <= 1'b0;
      sv_q <= 1'b0;
    end else if (prep_i) begin
      sd_q <= dvd[2*DW-1];
      sv_q <= dvs[DW-1];
    end
  end
`else
  assign dvd_mag = dvd;
  assign dvs_mag = dvs;

  always_comb begin
    fix_ovf = 1'b0;
    fix_q   = qr_q;
    fix_r   = p_q;
  end
`endif

  assign div_zero  = (dvs == '0);
  // High half >= divisor means the quotient needs more than DW bits.
  assign early_ovf = (dvd_mag[2*DW-1:DW] >= dvs_mag);
  assign early_o   = div_zero | early_ovf;

  // P < divisor holds every iteration, so T[DW] is the borrow/sign bit.
  assign t = {p_q, qr_q[DW-1]} - {1'b0, d_q};

  always_comb begin
    p_d  = p_q;
    qr_d = qr_q;
    if (prep_i) begin
      p_d  = dvd_mag[2*DW-1:DW];
      qr_d = dvd_mag[DW-1:0];
    end else if (calc_i) begin
      p_d  = t[DW] ? {p_q[DW-2:0], qr_q[DW-1]} : t[DW-1:0];
      qr_d = {qr_q[DW-2:0], ~t[DW]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q <= '0; p_q <= '0; qr_q <= '0; d_q <= '0;
      q_q <= '0; r_q <= '0; dz_q <= 1'b0; ovf_q <= 1'b0;
    end else if (clr_i) begin
      sh_q <= '0; p_q <= '0; qr_q <= '0; d_q <= '0;
      q_q <= '0; r_q <= '0; dz_q <= 1'b0; ovf_q <= 1'b0;
    end else begin
      if (shift_i) sh_q <= {sh_q[3*DW-9:0], in_data_i};
      p_q  <= p_d;
      qr_q <= qr_d;
      if (prep_i) begin
        d_q <= dvs_mag;
        if (div_zero) begin
          dz_q <= 1'b1;
          q_q  <= '1;
          r_q  <= dvd[DW-1:0];
        end else if (early_ovf) begin
          ovf_q <= 1'b1;
          q_q   <= '1;
          r_q   <= '0;
        end
      end
      if (fix_i) begin
        if (fix_ovf) begin
          ovf_q <= 1'b1;
          q_q   <= '1;
          r_q   <= '0;
        end else begin
          q_q <= fix_q;
          r_q <= fix_r;
        end
      end
      if (ack_i) begin
        dz_q  <= 1'b0;
        ovf_q <= 1'b0;
      end
    end
  end

  assign q_o   = q_q;
  assign r_o   = r_q;
  assign dz_o  = dz_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider, 2*DW-bit dividend / DW-bit divisor.
// Operands are loaded one byte per handshake (dividend MSB first, then
// divisor MSB first); the result is held with done until ack.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : seq_divider_if.slave (clr, byte handshake, done/ack, results)
// Optional feature: SIGNED_DIV_EN selects two's-complement operands.
module seq_divider
  import div_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);
  localparam int NB = nbytes(DW);
  localparam int BW = $clog2(NB);
  localparam int IW = cnt_w(DW);

  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_PREP = PREP;
  localparam logic [2:0] S_CALC = CALC;
  localparam logic [2:0] S_FIX  = FIX;
  localparam logic [2:0] S_DONE = DONE;

  logic [2:0]    st_q, st_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [IW-1:0] icnt_q, icnt_d;
  logic          acc, early;

  assign bus.in_ready = (st_q == S_IDLE);
  assign bus.busy     = (st_q == S_PREP) || (st_q == S_CALC) || (st_q == S_FIX);
  assign bus.done     = (st_q == S_DONE);
  assign acc          = bus.in_valid && (st_q == S_IDLE);

  always_comb begin
    st_d   = st_q;
    bcnt_d = bcnt_q;
    icnt_d = icnt_q;
    case (st_q)
      S_IDLE: if (acc) begin
        if (bcnt_q == BW'(NB-1)) begin
          bcnt_d = '0;
          st_d   = S_PREP;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      S_PREP: begin
        st_d   = early ? S_DONE : S_CALC;
        icnt_d = IW'(DW-1);
      end
      S_CALC: begin
        if (icnt_q == '0) st_d = S_FIX;
        else              icnt_d = icnt_q - IW'(1);
      end
      S_FIX:  st_d = S_DONE;
      S_DONE: if (bus.ack) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
    // Abort wins over every transition, including DONE+ack.
    if (bus.clr) begin
      st_d   = S_IDLE;
      bcnt_d = '0;
      icnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= S_IDLE;
      bcnt_q <= '0;
      icnt_q <= '0;
    end else begin
      st_q   <= st_d;
      bcnt_q <= bcnt_d;
      icnt_q <= icnt_d;
    end
  end

  div_dp #(.DW(DW)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (bus.clr),
    .shift_i   (acc),
    .in_data_i (bus.in_data),
    .prep_i    (st_q == S_PREP),
    .calc_i    (st_q == S_CALC),
    .fix_i     (st_q == S_FIX),
    .ack_i     ((st_q == S_DONE) && bus.ack),
    .early_o   (early),
    .q_o       (bus.q),
    .r_o       (bus.r),
    .dz_o      (bus.dz),
    .ovf_o     (bus.ovf)
  );
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a transaction-level divide model is
// compared against every output on every cycle, plus literal expectations.
module tb_seq_divider;
  import div_pkg::*;

  localparam int DW  = DW_DEF;
  localparam int LAT = DW + 2;
  localparam int TMO = 16 << CNT_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  seq_divider_if #(.DW(DW)) dif ();
  seq_divider #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(dif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void div_model(input logic [2*DW-1:0] dvd, input logic [DW-1:0] dvs,
                                    output logic [DW-1:0] q, output logic [DW-1:0] r,
                                    output logic dz, output logic ovf, output bit early);
    longint a, b, mq;
    dz = 1'b0; ovf = 1'b0; early = 1'b0; q = '0; r = '0;
    if (dvs == '0) begin
      dz = 1'b1; q = '1; r = dvd[DW-1:0]; early = 1'b1;
    end else begin
`ifdef SIGNED_DIV_EN
      a  = longint'($signed(dvd));
      b  = longint'($signed(dvs));
      mq = (a < 0 ? -a : a) / (b < 0 ? -b : b);
      if (mq >= (longint'(1) << DW)) begin
        ovf = 1'b1; q = '1; r = '0; early = 1'b1;
      end else if (mq > (((a < 0) != (b < 0)) ? (longint'(1) << (DW-1))
                                               : (longint'(1) << (DW-1)) - 1)) begin
        ovf = 1'b1; q = '1; r = '0;
      end else begin
        q = DW'(a / b);
        r = DW'(a % b);
      end
`else
      a  = longint'(dvd);
      b  = longint'(dvs);
      mq = a / b;
      if (mq >= (longint'(1) << DW)) begin
        ovf = 1'b1; q = '1; r = '0; early = 1'b1;
      end else begin
        q = DW'(mq);
        r = DW'(a % b);
      end
`endif
    end
  endfunction

  int                   m_ph, m_nb, m_rem;   // phase: 0 idle, 1 busy, 2 done
  logic [8*NBYTES-1:0]  m_buf;
  logic [DW-1:0]        m_q, m_r, p_q, p_r;
  logic                 m_dz, m_ovf, p_dz, p_ovf;
  bit                   p_early;

  task automatic model_reset();
    m_ph = 0; m_nb = 0; m_rem = 0;
    m_q = '0; m_r = '0; m_dz = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_step();
    if (dif.clr) begin
      model_reset();
    end else begin
      case (m_ph)
        0: if (dif.in_valid) begin
          m_buf = {m_buf[8*NBYTES-9:0], dif.in_data};
          m_nb++;
          if (m_nb == NBYTES) begin
            m_nb = 0;
            div_model(m_buf[8*NBYTES-1:DW], m_buf[DW-1:0], p_q, p_r, p_dz, p_ovf, p_early);
            m_rem = p_early ? 1 : LAT;
            m_ph  = 1;
          end
        end
        1: begin
          m_rem--;
          if (m_rem == 0) begin
            m_ph = 2; m_q = p_q; m_r = p_r; m_dz = p_dz; m_ovf = p_ovf;
          end
        end
        default: if (dif.ack) begin
          m_ph = 0; m_dz = 1'b0; m_ovf = 1'b0;
        end
      endcase
    end
  endtask

  // Compare process: model advances on each edge, outputs checked just after.
  initial begin
    model_reset();
    m_buf = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
      #1;
      chk("in_ready", 32'(dif.in_ready), 32'(m_ph == 0));
      chk("busy",     32'(dif.busy),     32'(m_ph == 1));
      chk("done",     32'(dif.done),     32'(m_ph == 2));
      chk("dz",       32'(dif.dz),       32'(m_dz));
      chk("ovf",      32'(dif.ovf),      32'(m_ovf));
      chk("q",        32'(dif.q),        32'(m_q));
      chk("r",        32'(dif.r),        32'(m_r));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    dif.in_data  = b;
    dif.in_valid = 1'b1;
    while (!dif.in_ready && g < TMO) begin @(negedge clk); g++; end
    if (!dif.in_ready) chk("in_ready_timeout", 32'(dif.in_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic send_op(input logic [2*DW-1:0] dvd, input logic [DW-1:0] dvs, input bit hold);
    logic [8*NBYTES-1:0] b;
    b = {dvd, dvs};
    for (int i = 0; i < NBYTES; i++) send_byte(b[8*NBYTES-1-8*i -: 8]);
    if (!hold) dif.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!dif.done && n < TMO) begin @(negedge clk); n++; end
    if (!dif.done) chk("done_timeout", 32'(dif.done), 32'd1);
  endtask

  task automatic ack_pulse();
    dif.ack = 1'b1;
    @(negedge clk);
    dif.ack = 1'b0;
  endtask

  task automatic run(input string nm, input logic [31:0] dvd, input logic [15:0] dvs,
                     input int lat, input logic [15:0] eq, input logic [15:0] er,
                     input logic edz, input logic eovf);
    int n;
    send_op(dvd, dvs, 1'b0);
    wait_done(n);
    chk({nm, "_lat"}, 32'(n), 32'(lat));
    chk({nm, "_q"},   32'(dif.q),   32'(eq));
    chk({nm, "_r"},   32'(dif.r),   32'(er));
    chk({nm, "_dz"},  32'(dif.dz),  32'(edz));
    chk({nm, "_ovf"}, 32'(dif.ovf), 32'(eovf));
    ack_pulse();
  endtask

  initial begin
    int n, t1, t2;
    dif.clr = 1'b0; dif.in_valid = 1'b0; dif.in_data = 8'h00; dif.ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(dif.in_ready), 32'd1);
    chk("rst_done",     32'(dif.done),     32'd0);
    chk("rst_q",        32'(dif.q),        32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run("u1000_7", 32'd1000,       16'd7,      18, 16'h008E, 16'h0006, 1'b0, 1'b0);
    run("dz",      32'h12345678,   16'h0000,    1, 16'hFFFF, 16'h5678, 1'b1, 1'b0);
    run("eovf",    32'h00010000,   16'h0001,    1, 16'hFFFF, 16'h0000, 1'b0, 1'b1);

    // reset in the 5th CALC cycle, then a fresh operation
    send_op(32'h0000FFFF, 16'h00FF, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_q",        32'(dif.q),        32'd0);
    chk("midrst_busy",     32'(dif.busy),     32'd0);
    chk("midrst_in_ready", 32'(dif.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run("ffff_ff", 32'h0000FFFF, 16'h00FF, 18, 16'h0101, 16'h0000, 1'b0, 1'b0);

`ifdef SIGNED_DIV_EN
    run("sneg1000_7", 32'hFFFFFC18, 16'h0007, 18, 16'hFF72, 16'hFFFA, 1'b0, 1'b0);
    run("sfixovf",    32'h00008000, 16'h0001, 18, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
`else
    run("u8000_1",    32'h00008000, 16'h0001, 18, 16'h8000, 16'h0000, 1'b0, 1'b0);
`endif

    // back-to-back: in_valid held high, ack held high so it lands as done rises
    dif.ack = 1'b1;
    send_op(32'd1000, 16'd7, 1'b1);
    dif.in_data = 8'h00;
    wait_done(n);
    t1 = cyc;
    chk("b2b1_q", 32'(dif.q), 32'h008E);
    send_op(32'h00FFFFFF, 16'h1000, 1'b0);
    wait_done(n);
    t2 = cyc;
    chk("b2b2_q",   32'(dif.q), 32'h0FFF);
    chk("b2b2_r",   32'(dif.r), 32'h0FFF);
    chk("b2b_gap",  32'(t2 - t1), 32'd25);
    @(negedge clk);
    dif.ack = 1'b0;

    // clr after 3 bytes restarts the byte count
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    dif.in_valid = 1'b0;
    dif.clr = 1'b1;
    @(negedge clk);
    dif.clr = 1'b0;
    send_op(32'd100000, 16'd300, 1'b0);
    wait_done(n);
    chk("clr_lat", 32'(n), 32'd18);
    chk("clr_q",   32'(dif.q), 32'h014D);
    chk("clr_r",   32'(dif.r), 32'h0064);
    // clr together with ack in DONE: clr wins and clears the result
    dif.ack = 1'b1; dif.clr = 1'b1;
    @(negedge clk);
    dif.ack = 1'b0; dif.clr = 1'b0;
    chk("clrack_q",        32'(dif.q),        32'd0);
    chk("clrack_in_ready", 32'(dif.in_ready), 32'd1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential radix-2 restoring divider: 32-bit dividend by 16-bit divisor, producing a 16-bit quotient and a 16-bit remainder. It is the inverse companion of the radix-4 Booth multiplier datapath and shares its byte-wide operand loading style. It has its own controller and datapath, and it sits on the same 8-bit operand bus as the multiplier.

## Interface
- DW, 16: divisor, quotient and remainder width. Must be a multiple of 8. Dividend width is 2*DW.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous abort; returns the block to IDLE with the byte count at 0
- in_valid  in  1  operand byte valid
- in_ready  out  1  high only in IDLE
- in_data  in  8  operand byte; order is dividend MSB first (4 bytes), then divisor MSB first (2 bytes)
- busy  out  1  high in PREP, CALC and FIX
- done  out  1  result valid; held until ack
- ack  in  1  result consumed
- q  out  DW  quotient
- r  out  DW  remainder
- dz  out  1  divide-by-zero flag
- ovf  out  1  quotient does not fit in DW bits

## Operation
- Reset (rst, or clr at a clock edge):
  - state = IDLE, byte count = 0.
  - All outputs are 0 except in_ready = 1.
- A byte transfers on an edge where in_valid & in_ready are both high. The 3*DW/8-th accepted byte moves the block to PREP.
- PREP, one cycle:
  - Divisor = 0: dz=1, q=all ones, r=dividend[DW-1:0]. Go to DONE.
  - Otherwise, dividend[2DW-1:DW] >= divisor (after magnitude conversion): ovf=1, q=all ones, r=0. Go to DONE.
  - Otherwise, load partial remainder P = dividend[2DW-1:DW] and shift register Q = dividend[DW-1:0]. Go to CALC.
- CALC, DW cycles, one per quotient bit:
  - T = {P, Q[DW-1]} - {1'b0, divisor}, DW+1 bits wide.
  - If T is non-negative: P = T[DW-1:0] and the new quotient bit is 1.
  - Otherwise P = {P[DW-2:0], Q[DW-1]} (restore) and the new quotient bit is 0.
  - Q shifts left by one and the new quotient bit enters at Q[0].
  - An iteration counter runs from DW-1 down to 0; the block leaves for FIX when it reaches 0.
- FIX, one cycle: load q=Q and r=P (with sign correction, see Configuration). Go to DONE.
- DONE:
  - done=1 and q, r, dz, ovf are stable.
  - ack moves the block to IDLE at the next edge, where done, dz and ovf clear.
  - q and r hold their values until the next FIX or PREP load.
- ack outside DONE is ignored. in_valid outside IDLE is ignored; no byte is consumed.
- clr has priority over every transition, including a DONE+ack in the same cycle.

## Timing
- Let E0 be the edge that accepts the last operand byte.
- Normal path: PREP at E0, CALC from E1 to E16, FIX at E17, done=1 after E18. Latency is DW+2 cycles.
- dz or early ovf path: done=1 after E1.
- ack sampled high at edge Ek: done=0 and in_ready=1 after Ek. The first byte of the next operation can be accepted at Ek+1.
- Minimum time between results is 6 + 18 + 1 cycles, with in_valid held high.
- rst mid-CALC clears everything immediately and the partial result is lost. clr has the same effect at the next edge.

## Configuration
- SIGNED_DIV_EN defined: operands are two's complement.
  - PREP records the sign of the dividend (sd) and the divisor (sv), then loads their magnitudes.
  - The early overflow check uses the magnitudes.
  - FIX negates q if sd^sv and negates r if sd, so the result truncates toward zero.
  - FIX also sets ovf (q=all ones, r=0) if the magnitude quotient exceeds 2^(DW-1)-1, or exceeds 2^(DW-1) for a negative result.
  - Divisor = 0 behaves as in the unsigned case.
- SIGNED_DIV_EN undefined: the divider is unsigned only. No sign registers or negators are built.

## Structure
- Package div_pkg holds:
  - the state enum {IDLE, PREP, CALC, FIX, DONE};
  - DW_DEF=16 and the byte-count constant NBYTES=3*DW/8;
  - the counter width localparam $clog2(DW).
- seq_divider contains the controller (FSM, byte counter, iteration counter).
- One sub-module, div_dp, holds the datapath: byte shift-in registers, P/Q registers, the DW+1-bit subtractor, and the sign fix-up logic.

## Test plan
- Unsigned 1000/7: bytes 00 00 03 E8 00 07 -> q=0x008E, r=0x0006, dz=0, ovf=0, done exactly 18 cycles after the last byte.
- Divide by zero: bytes 12 34 56 78 00 00 -> dz=1, q=0xFFFF, r=0x5678, done 1 cycle after the last byte.
- Early overflow: dividend 0x00010000, divisor 0x0001 -> ovf=1, q=0xFFFF, r=0x0000, done 1 cycle after the last byte.
- SIGNED_DIV_EN, -1000/7: bytes FF FF FC 18 00 07 -> q=0xFF72, r=0xFFFA. With dividend 0x00008000 and divisor 0x0001 -> ovf=1 set in FIX.
- rst asserted in the 5th CALC cycle -> all outputs 0 and in_ready=1 immediately. Then 0x0000FFFF/0x00FF -> q=0x0101, r=0x0000.
- Back-to-back: two operations with in_valid held high and ack asserted the same cycle done rises -> second byte stream starts the cycle after ack; both results are correct. clr after 3 bytes -> byte count restarts, and the next 6 bytes form a fresh operand.
